apb_master_ctrl: RTL and testbench

Requester-side APB controller for the apb2apb bridge: accepts single read/write commands on a valid/ready command port, runs the APB IDLE→SETUP→ACCESS sequence toward a downstream `apb_slave`, and returns read data and error status as a one-cycle response pulse. Back-to-back transfers go ACCESS→SETUP directly via `trnsfr`. A programmable wait-state timeout bounds every transfer.

---
 rtl/apb_pkg.sv | 12 +
 rtl/apb_wait_timer.sv | 19 +
 rtl/apb_master_ctrl.sv | 98 +++++++++
 tb/tb_apb_master_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared states, default widths and response record for the APB requester
package apb_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_TIMEOUT = 16;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  slverr;
    logic                  timeout;
  } rsp_t;
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: saturating ACCESS wait-state counter flagging when TIMEOUT is reached
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expired = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT);
endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-command APB requester with back-to-back transfers and wait-state timeout
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strobe,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic                    sel,
  output logic                    enable,
  output logic                    write,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] strobe,
  output logic                    trnsfr,
  input  logic                    ready,
  input  logic                    slverr,
  input  logic [DATA_WIDTH-1:0]   rdata
);
  state_e state_q, state_d;
  logic write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] strobe_q, strobe_d;
  logic rsp_valid_q, rsp_valid_d;
  rsp_t rsp_q, rsp_d;
  logic expired, accept, done;
  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk,
    .rst,
    .clr(state_q == SETUP),
    .inc(state_q == ACCESS && !ready),
    .expired
  );
  assign cmd_ready = !rst && (state_q == IDLE || (state_q == ACCESS && ready));
  assign accept = cmd_valid && cmd_ready;
  assign done = state_q == ACCESS && (ready || expired);
  always_comb begin
    state_d = state_q == SETUP ? ACCESS : done ? IDLE : state_q;
    write_d = done ? 1'b0 : write_q;
    addr_d = done ? '0 : addr_q;
    wdata_d = done ? '0 : wdata_q;
    strobe_d = done ? '0 : strobe_q;
    rsp_valid_d = done;
    rsp_d.rdata = (done && ready && !write_q) ? APB_DATA_W'(rdata) : '0;
    rsp_d.slverr = done && (ready ? slverr : 1'b1);
    rsp_d.timeout = done && !ready;
    if (accept) begin
      state_d = SETUP;
      write_d = cmd_write;
      addr_d = cmd_addr;
      wdata_d = cmd_wdata;
      strobe_d = cmd_write ? cmd_strobe : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      strobe_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      strobe_q <= strobe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q <= rsp_d;
    end
  end
  assign sel = state_q != IDLE;
  assign enable = state_q == ACCESS;
  assign trnsfr = state_q == ACCESS && cmd_valid;
  assign write = write_q;
  assign addr = addr_q;
  assign wdata = wdata_q;
  assign strobe = strobe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = DATA_WIDTH'(rsp_q.rdata);
  assign rsp_slverr = rsp_q.slverr;
  assign rsp_timeout = rsp_q.timeout;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: random commands against a word memory slave, checked by a transaction-level model
module tb_apb_master_ctrl;
  localparam int TMO = 4;
  localparam int MEM_SIZE = 64;
  logic clk = 0;
  logic rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0] cmd_strobe = 0;
  logic rsp_valid, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic sel, enable, write, trnsfr;
  logic [31:0] addr, wdata;
  logic [3:0] strobe;
  logic ready = 0, slverr = 0;
  logic [31:0] rdata = 0;
  int n_chk = 0, n_pass = 0;
  int slv_waits = 0;
  logic [31:0] ref_mem [16];
  apb_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strobe(cmd_strobe),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout), .sel(sel), .enable(enable), .write(write),
    .addr(addr), .wdata(wdata), .strobe(strobe), .trnsfr(trnsfr),
    .ready(ready), .slverr(slverr), .rdata(rdata)
  );
  always #5 clk = ~clk;
  initial begin
    logic [31:0] slv_mem [16];
    int acc_cnt;
    acc_cnt = 0;
    for (int i = 0; i < 16; i++) slv_mem[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      ready = 0;
      slverr = 0;
      rdata = 0;
      if (sel && !enable) acc_cnt = 0;
      else if (sel && enable) begin
        if (acc_cnt >= slv_waits) begin
          ready = 1;
          slverr = addr >= MEM_SIZE;
          if (!slverr && write) begin
            for (int b = 0; b < 4; b++)
              if (strobe[b]) slv_mem[addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
          end else if (!slverr) rdata = slv_mem[addr[5:2]];
        end
        acc_cnt++;
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
  endtask
  task automatic wait_cmd_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
  endtask
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int waits);
    bit to, err;
    logic [31:0] exp_rd;
    int lat;
    to = waits > TMO;
    err = to || a >= MEM_SIZE;
    exp_rd = (w || err) ? 32'h0 : ref_mem[a[5:2]];
    if (w && !err) model_write(a, d, s);
    slv_waits = waits;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_strobe = s;
    cmd_valid = 1;
    wait_cmd_ready();
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    chk("setup_ctl", {sel, enable, cmd_ready}, 3'b100);
    chk("setup_addr", addr, a);
    chk("setup_wdata", wdata, d);
    chk("setup_write", write, w);
    chk("setup_strobe", strobe, w ? s : 4'b0);
    @(negedge clk);
    chk("access_ctl", {sel, enable, trnsfr}, 3'b110);
    chk("access_addr", addr, a);
    lat = 2;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 3 + (to ? TMO : waits));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err_to", {rsp_slverr, rsp_timeout}, {err, to});
    @(negedge clk);
    chk("rsp_pulse_idle", {rsp_valid, sel, addr}, 0);
  endtask
  initial begin
    logic [31:0] a, d;
    int seen;
    for (int i = 0; i < 16; i++) ref_mem[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", {cmd_ready, rsp_valid, sel, enable, write, trnsfr, |addr, |wdata, |strobe, |rsp_rdata, rsp_slverr, rsp_timeout}, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);
    do_txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    do_txn(1, 32'h14, 32'h12345678, 4'hF, 0);
    do_txn(0, 32'h14, 32'hFFFFFFFF, 4'hF, 2);
    do_txn(0, 32'h10, 32'h0, 4'h0, 1000);
    do_txn(0, 32'h80, 32'h0, 4'h0, 0);
    do_txn(0, 32'h10, 32'h0, 4'h0, TMO);
    d = 32'hA5C3_0F1E;
    slv_waits = 0;
    cmd_write = 1;
    cmd_addr = 32'h20;
    cmd_wdata = d;
    cmd_strobe = 4'hF;
    cmd_valid = 1;
    wait_cmd_ready();
    @(posedge clk);
    @(negedge clk);
    model_write(32'h20, d, 4'hF);
    cmd_write = 0;
    cmd_addr = 32'h20;
    cmd_wdata = 0;
    @(negedge clk);
    chk("b2b_trnsfr", {trnsfr, cmd_ready}, 2'b11);
    @(negedge clk);
    chk("b2b_setup", {rsp_valid, sel, enable, write}, 4'b1100);
    chk("b2b_addr", addr, 32'h20);
    cmd_valid = 0;
    @(negedge clk);
    chk("b2b_gap", {rsp_valid, enable}, 2'b01);
    @(negedge clk);
    chk("b2b_rsp2", {rsp_valid, rsp_rdata}, {1'b1, ref_mem[8]});
    @(negedge clk);
    slv_waits = 3;
    cmd_write = 0;
    cmd_addr = 32'h8;
    cmd_valid = 1;
    wait_cmd_ready();
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_mid", {cmd_ready, rsp_valid, sel, enable, write, trnsfr, |addr, |wdata, |strobe}, 0);
    rst = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rst_no_rsp", seen, 0);
    do_txn(0, 32'h20, 32'h0, 4'h0, 1);
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 19)) * 4;
      d = $urandom;
      do_txn(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 6));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
